count_up_seq: RTL and testbench

Sequential 16-bit loadable up-counter: the registered, opposite-direction counterpart to the combinational down-count next-state logic in the benchmark set. It holds the count in flops and increments it under an enable. A start value is loaded through a valid/ready handshake, and a force-set drives the count to all ones. Wrap from all ones raises a one-cycle terminal-count pulse, with optional auto-reload of the last loaded value. It is the sequential reference design the combinational counter benchmarks are checked against.

---
 rtl/count_up_seq.sv | 86 ++++++++
 tb/tb_count_up_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_up_seq.sv
// Loadable up-counter with force-set, stop and wrap pulse; count/busy/tc registered, load visible one edge after accept.
// Backpressure: ld_ready is low outside IDLE, during set and during rst; offers are simply not taken then.
module count_up_seq #(
    parameter int WIDTH       = 16,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             stop,
    input  logic             en,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic             tc_nxt;

    // ld_ready depends only on state, set and rst so ld_valid never loops back into it
    assign ld_ready = (state == IDLE) && !set && !rst;
    assign busy     = (state == RUN);

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        tc_nxt     = 1'b0;
        if (set) begin
            count_nxt = ALL_ONES;
            if (stop) begin
                state_nxt = IDLE;
            end
        end else if (stop) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            if (ld_valid && ld_ready) begin
                count_nxt  = ld_data;
                reload_nxt = ld_data;
                state_nxt  = RUN;
            end
        end else if (en) begin
            if (count == ALL_ONES) begin
                tc_nxt = 1'b1;
                if (AUTO_RELOAD != 0) begin
                    count_nxt = reload;
                end else begin
                    count_nxt = '0;
                    state_nxt = IDLE;
                end
            end else begin
                count_nxt = count + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            tc     <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_count_up_seq.sv
// Bench for count_up_seq: one instance per AUTO_RELOAD setting, directed scenarios plus random run against a model.
module tb_count_up_seq;

    localparam int unsigned MOD = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0;
    logic        stop = 1'b0;
    logic        en = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = 16'h0000;

    logic        ld_ready0, busy0, tc0;
    logic [15:0] count0;
    logic        ld_ready1, busy1, tc1;
    logic [15:0] count1;

    int n_cmp = 0;
    int n_err = 0;

    // model: index 0 -> no reload, index 1 -> auto reload
    bit          m_run[2];
    int unsigned m_cnt[2];
    int unsigned m_rel[2];
    bit          m_tc[2];

    always #5 clk = ~clk;

    count_up_seq #(.WIDTH(16), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .rst(rst), .set(set), .stop(stop), .en(en),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0),
        .count(count0), .busy(busy0), .tc(tc0)
    );

    count_up_seq #(.WIDTH(16), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .rst(rst), .set(set), .stop(stop), .en(en),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1),
        .count(count1), .busy(busy1), .tc(tc1)
    );

    // advance one clock edge and apply the rules to the model with the inputs present at that edge
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 1'b0;
            if (rst) begin
                m_run[i] = 1'b0;
                m_cnt[i] = 0;
                m_rel[i] = 0;
            end else if (set) begin
                m_cnt[i] = MOD - 1;
                if (stop) m_run[i] = 1'b0;
            end else if (stop) begin
                m_run[i] = 1'b0;
            end else if (!m_run[i]) begin
                if (ld_valid) begin
                    m_cnt[i] = ld_data;
                    m_rel[i] = ld_data;
                    m_run[i] = 1'b1;
                end
            end else if (en) begin
                if (m_cnt[i] + 1 == MOD) begin
                    m_tc[i] = 1'b1;
                    if (i == 1) begin
                        m_cnt[i] = m_rel[i];
                    end else begin
                        m_cnt[i] = 0;
                        m_run[i] = 1'b0;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; set = 1'b0; stop = 1'b0; en = 1'b0; ld_valid = 1'b1; ld_data = 16'h4444;
        tick();
        tick();
        n_cmp++; if (ld_ready0 !== 1'b0) begin n_err++; $display("FAIL reset_ready_low got=%b exp=0", ld_ready0); end
        n_cmp++; if (count0 !== 16'h0000) begin n_err++; $display("FAIL reset_count got=%h exp=0000", count0); end
        n_cmp++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b%b exp=00", busy0, busy1); end
        n_cmp++; if (tc0 !== 1'b0 || tc1 !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b%b exp=00", tc0, tc1); end
        rst = 1'b0; ld_valid = 1'b0;
        #1;
        n_cmp++; if (ld_ready0 !== 1'b1 || ld_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_ready_high got=%b%b exp=11", ld_ready0, ld_ready1); end
    endtask

    task automatic test_load_count();
        ld_valid = 1'b1; ld_data = 16'h1234; en = 1'b1;
        tick();
        ld_valid = 1'b0;
        n_cmp++; if (count0 !== 16'h1234 || busy0 !== 1'b1) begin n_err++; $display("FAIL load_accept got=%h/%b exp=1234/1", count0, busy0); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (count0 !== 16'(16'h1234 + k) || tc0 !== 1'b0 || busy0 !== 1'b1)
                begin n_err++; $display("FAIL load_inc%0d got=%h/%b/%b exp=%h/0/1", k, count0, tc0, busy0, 16'(16'h1234 + k)); end
        end
        stop = 1'b1; en = 1'b0;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_wrap_noreload();
        ld_valid = 1'b1; ld_data = 16'hFFFE; en = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        n_cmp++; if (count0 !== 16'hFFFF || tc0 !== 1'b0) begin n_err++; $display("FAIL wrap0_pre got=%h/%b exp=ffff/0", count0, tc0); end
        tick();
        n_cmp++; if (count0 !== 16'h0000 || tc0 !== 1'b1 || busy0 !== 1'b0 || ld_ready0 !== 1'b1)
            begin n_err++; $display("FAIL wrap0_post got=%h/tc%b/busy%b/rdy%b exp=0000/1/0/1", count0, tc0, busy0, ld_ready0); end
        n_cmp++; if (count1 !== 16'hFFFE || tc1 !== 1'b1 || busy1 !== 1'b1)
            begin n_err++; $display("FAIL wrap1_post got=%h/tc%b/busy%b exp=fffe/1/1", count1, tc1, busy1); end
        tick();
        n_cmp++; if (count0 !== 16'h0000 || tc0 !== 1'b0 || busy0 !== 1'b0)
            begin n_err++; $display("FAIL wrap0_idle got=%h/tc%b/busy%b exp=0000/0/0", count0, tc0, busy0); end
        stop = 1'b1; en = 1'b0;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_wrap_reload();
        logic [15:0] exp_c [6] = '{16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFD};
        logic        exp_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ld_valid = 1'b1; ld_data = 16'hFFFD; en = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++; if (count1 !== exp_c[k] || tc1 !== exp_t[k] || busy1 !== 1'b1)
                begin n_err++; $display("FAIL reload_step%0d got=%h/tc%b/busy%b exp=%h/%b/1", k, count1, tc1, busy1, exp_c[k], exp_t[k]); end
        end
        stop = 1'b1; en = 1'b0;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_set_priority();
        ld_valid = 1'b1; ld_data = 16'h000F; en = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        n_cmp++; if (count0 !== 16'h0010) begin n_err++; $display("FAIL set_setup got=%h exp=0010", count0); end
        en = 1'b0; set = 1'b1; ld_valid = 1'b1; ld_data = 16'h5555;
        tick();
        n_cmp++; if (count0 !== 16'hFFFF || busy0 !== 1'b1 || tc0 !== 1'b0 || count1 !== 16'hFFFF)
            begin n_err++; $display("FAIL set_run got=%h/%h busy%b tc%b exp=ffff/ffff/1/0", count0, count1, busy0, tc0); end
        set = 1'b0; ld_valid = 1'b0; en = 1'b1;
        tick();
        n_cmp++; if (count0 !== 16'h0000 || tc0 !== 1'b1 || busy0 !== 1'b0)
            begin n_err++; $display("FAIL set_wrap0 got=%h/tc%b/busy%b exp=0000/1/0", count0, tc0, busy0); end
        n_cmp++; if (count1 !== 16'h000F || tc1 !== 1'b1 || busy1 !== 1'b1)
            begin n_err++; $display("FAIL set_wrap1 got=%h/tc%b/busy%b exp=000f/1/1", count1, tc1, busy1); end
        en = 1'b0; set = 1'b1; ld_valid = 1'b1; ld_data = 16'h2222;
        #1;
        n_cmp++; if (ld_ready0 !== 1'b0) begin n_err++; $display("FAIL set_idle_ready got=%b exp=0", ld_ready0); end
        tick();
        n_cmp++; if (count0 !== 16'hFFFF || busy0 !== 1'b0) begin n_err++; $display("FAIL set_idle got=%h/busy%b exp=ffff/0", count0, busy0); end
        set = 1'b0; ld_valid = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_en_stop();
        logic        en_seq [3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] exp_c  [3] = '{16'h00A1, 16'h00A1, 16'h00A2};
        ld_valid = 1'b1; ld_data = 16'h00A0; en = 1'b0;
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en = en_seq[k];
            tick();
            n_cmp++; if (count0 !== exp_c[k] || tc0 !== 1'b0) begin n_err++; $display("FAIL en_step%0d got=%h/tc%b exp=%h/0", k, count0, tc0, exp_c[k]); end
        end
        stop = 1'b1; en = 1'b1;
        tick();
        n_cmp++; if (count0 !== 16'h00A2 || busy0 !== 1'b0 || tc0 !== 1'b0)
            begin n_err++; $display("FAIL stop got=%h/busy%b/tc%b exp=00a2/0/0", count0, busy0, tc0); end
        stop = 1'b0;
        tick();
        n_cmp++; if (count0 !== 16'h00A2 || busy0 !== 1'b0) begin n_err++; $display("FAIL idle_en got=%h/busy%b exp=00a2/0", count0, busy0); end
        en = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        ld_valid = 1'b1; ld_data = 16'h7FFF; en = 1'b0;
        tick();
        ld_valid = 1'b0; rst = 1'b1; en = 1'b1;
        tick();
        n_cmp++; if (count0 !== 16'h0000 || busy0 !== 1'b0 || tc0 !== 1'b0 || count1 !== 16'h0000 || tc1 !== 1'b0)
            begin n_err++; $display("FAIL rst_run got=%h/%h busy%b tc%b%b exp=0000/0000/0/00", count0, count1, busy0, tc0, tc1); end
        n_cmp++; if (ld_ready0 !== 1'b0) begin n_err++; $display("FAIL rst_ready_low got=%b exp=0", ld_ready0); end
        rst = 1'b0; en = 1'b0;
        #1;
        n_cmp++; if (ld_ready0 !== 1'b1) begin n_err++; $display("FAIL rst_ready_high got=%b exp=1", ld_ready0); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            set      = ($urandom_range(0, 31) == 0);
            stop     = ($urandom_range(0, 31) == 0);
            en       = ($urandom_range(0, 3) != 0);
            ld_valid = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       ld_data = 16'hFFFF;
                1:       ld_data = 16'($urandom_range(0, 65535));
                default: ld_data = 16'($urandom_range(65528, 65534));
            endcase
            #1;
            n_cmp++; if (ld_ready0 !== (!rst && !set && !m_run[0])) begin n_err++; $display("FAIL rnd%0d ready0 got=%b exp=%b", c, ld_ready0, !rst && !set && !m_run[0]); end
            n_cmp++; if (ld_ready1 !== (!rst && !set && !m_run[1])) begin n_err++; $display("FAIL rnd%0d ready1 got=%b exp=%b", c, ld_ready1, !rst && !set && !m_run[1]); end
            tick();
            n_cmp++; if (count0 !== 16'(m_cnt[0])) begin n_err++; $display("FAIL rnd%0d count0 got=%h exp=%h", c, count0, 16'(m_cnt[0])); end
            n_cmp++; if (busy0 !== m_run[0]) begin n_err++; $display("FAIL rnd%0d busy0 got=%b exp=%b", c, busy0, m_run[0]); end
            n_cmp++; if (tc0 !== m_tc[0]) begin n_err++; $display("FAIL rnd%0d tc0 got=%b exp=%b", c, tc0, m_tc[0]); end
            n_cmp++; if (count1 !== 16'(m_cnt[1])) begin n_err++; $display("FAIL rnd%0d count1 got=%h exp=%h", c, count1, 16'(m_cnt[1])); end
            n_cmp++; if (busy1 !== m_run[1]) begin n_err++; $display("FAIL rnd%0d busy1 got=%b exp=%b", c, busy1, m_run[1]); end
            n_cmp++; if (tc1 !== m_tc[1]) begin n_err++; $display("FAIL rnd%0d tc1 got=%b exp=%b", c, tc1, m_tc[1]); end
        end
        rst = 1'b0; set = 1'b0; stop = 1'b0; en = 1'b0; ld_valid = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_load_count();
        test_wrap_noreload();
        test_wrap_reload();
        test_set_priority();
        test_en_stop();
        test_rst_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
